// File: rtl/button_pulser.sv
// Push-button conditioner: synchronizer, debounce FSM, single-cycle press strobe.
// Define BTN_LONG_PRESS_EN to build the long-hold strobe; otherwise long_press is tied to 0.
module button_pulser #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_W           = 17,
   parameter int unsigned LONG_CYCLES     = 10000000,
   parameter int unsigned LONG_W          = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic lockout,
   output logic button,
   output logic btn_level,
   output logic long_press
);

   // Elaboration-time sanity checks on the configuration.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("button_pulser: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1 ||
       (longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
      $error("button_pulser: DEBOUNCE_CYCLES must be >= 1 and fit CNT_W");
   end
   if (LONG_CYCLES < 1 ||
       (longint'(LONG_CYCLES) - 1) >= (longint'(1) << LONG_W)) begin : g_bad_long
      $error("button_pulser: LONG_CYCLES must be >= 1 and fit LONG_W");
   end

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StPressed,
      StReleaseWait
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   press_accept;
   logic                   button_q;
   logic                   level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      press_accept = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d      = StPressed;
               cnt_d        = '0;
               press_accept = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            if (!s) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end
         end
         StReleaseWait: begin
            // A bounce back to 1 resumes the press without a second strobe.
            if (s) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         button_q <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         button_q <= press_accept & ~lockout;
         level_q  <= (state_d == StPressed) || (state_d == StReleaseWait);
      end
   end

   assign button    = button_q;
   assign btn_level = level_q;

`ifdef BTN_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] LongMax   = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LongPre   = LONG_W'(LONG_CYCLES - 2);
   localparam bit                LongIsOne = (LONG_CYCLES == 1);

   logic [LONG_W-1:0] lcnt_q, lcnt_d;
   logic              lcnt_inc;
   logic              long_fire;
   logic              long_q;

   always_comb begin
      lcnt_d    = lcnt_q;
      lcnt_inc  = 1'b0;
      long_fire = 1'b0;
      if (state_d == StIdle) begin
         lcnt_d = '0;
      end else if (state_q == StPressed && lcnt_q != LongMax) begin
         lcnt_inc = 1'b1;
         lcnt_d   = lcnt_q + LONG_W'(1);
      end
      // With a one-cycle threshold the counter is already at its limit on PRESSED entry.
      if (LongIsOne) begin
         long_fire = press_accept;
      end else begin
         long_fire = lcnt_inc && (lcnt_q == LongPre);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         long_q <= long_fire & ~lockout;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_pulser.sv
// Self-checking bench for button_pulser: directed scenarios then randomized bouncing input,
// compared against a run-length reference model of the debounced button.
module tb_button_pulser;

   localparam int unsigned S = 2;
   localparam int unsigned D = 4;
   localparam int unsigned L = 8;
`ifdef BTN_LONG_PRESS_EN
   localparam bit LongEn = 1'b1;
`else
   localparam bit LongEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b0;
   logic lockout = 1'b0;
   logic button, btn_level, long_press;

   int tests = 0;
   int fails = 0;

   // Reference model: level flips once D+1 consecutive synchronized samples disagree with it.
   bit raw_hist[$];
   bit m_lvl;
   int m_run;
   int m_h;
   bit e_btn, e_lvl, e_long;

   button_pulser #(
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3),
      .LONG_CYCLES    (L),
      .LONG_W         (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .lockout   (lockout),
      .button    (button),
      .btn_level (btn_level),
      .long_press(long_press)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_hist.delete();
      m_lvl  = 1'b0;
      m_run  = 0;
      m_h    = 0;
      e_btn  = 1'b0;
      e_lvl  = 1'b0;
      e_long = 1'b0;
   endtask

   task automatic model_edge(input bit raw, input bit lock);
      bit s, held, flip, fire;
      s = (raw_hist.size() >= S) ? raw_hist[raw_hist.size() - S] : 1'b0;
      raw_hist.push_back(raw);
      if (raw_hist.size() > 8) void'(raw_hist.pop_front());
      held = m_lvl && (m_run == 0);
      flip = 1'b0;
      fire = 1'b0;
      if (s != m_lvl) begin
         m_run++;
         if (m_run == D + 1) begin
            m_lvl = !m_lvl;
            m_run = 0;
            flip  = 1'b1;
         end
      end else begin
         m_run = 0;
      end
      if (held && m_h < L - 1) begin
         m_h++;
         fire = (m_h == L - 1);
      end
      if (flip && m_lvl && L == 1) fire = 1'b1;
      if (flip && !m_lvl) m_h = 0;
      e_btn  = flip && m_lvl && !lock;
      e_lvl  = m_lvl;
      e_long = LongEn && fire && !lock;
   endtask

   task automatic tick(input bit raw, input bit lock);
      btn_raw = raw;
      lockout = lock;
      @(posedge clk);
      model_edge(raw, lock);
      #1;
      check("model_button", button, e_btn);
      check("model_level", btn_level, e_lvl);
      check("model_long", long_press, e_long);
   endtask

   task automatic do_reset();
      #3 rst = 1'b1;
      #1;
      check("reset_button", button, 1'b0);
      check("reset_level", btn_level, 1'b0);
      check("reset_long", long_press, 1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int pulses;
      model_reset();
      #1;
      check("init_button", button, 1'b0);
      check("init_level", btn_level, 1'b0);
      check("init_long", long_press, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Clean press and release.
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, 1'b0);
         check("clean_press_button", button, i == 6);
         check("clean_press_level", btn_level, i >= 6);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0);
         check("clean_release_level", btn_level, i < 6);
      end

      // Bounce shorter than the debounce window.
      for (int i = 0; i < 12; i++) begin
         tick((i < 4) ? ((i % 2) == 0) : 1'b0, 1'b0);
         check("bounce_button", button, 1'b0);
         check("bounce_level", btn_level, 1'b0);
      end

      // Long hold then release.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0);
         if (button) pulses++;
         check("hold_long", long_press, LongEn && (i == 13));
      end
      check("hold_one_pulse", pulses == 1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0);
         check("hold_release_level", btn_level, i < 6);
         check("hold_release_long", long_press, 1'b0);
      end

      // Release bounce while pressed.
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0);
         if (button) pulses++;
      end
      for (int i = 0; i < 8; i++) begin
         tick((i >= 2), 1'b0);
         check("relbounce_level", btn_level, 1'b1);
         check("relbounce_button", button, 1'b0);
      end
      check("relbounce_one_pulse", pulses == 1, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

      // Lockout across the PRESSED entry edge.
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, i < 8);
         check("lockout_button", button, 1'b0);
         check("lockout_level", btn_level, i >= 6);
      end
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

      // Reset mid-press with the button still held.
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
      check("midpress_level", btn_level, 1'b1);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0);
         check("post_reset_button", button, i == 6);
      end
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

      // Randomized bouncing, holds, lockout and resets.
      for (int seg = 0; seg < 250; seg++) begin
         bit raw, lock;
         int len;
         raw  = 1'($urandom_range(0, 1));
         lock = ($urandom_range(0, 3) == 0);
         len  = $urandom_range(1, (seg % 5 == 0) ? 14 : 7);
         if ($urandom_range(0, 49) == 0) do_reset();
         for (int k = 0; k < len; k++) tick(raw, lock);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
